// File: rtl/data_path_router_pkg.sv
// Shared definitions for the data-side router: FSM state encoding and
// access-size codes carried on the cpu/cache/uncached request buses.
package data_path_router_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    C_WAIT  = 2'd1,
    UC_ADDR = 2'd2,
    UC_DATA = 2'd3
  } state_t;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

endpackage

// File: rtl/uc_req_buffer.sv
// Holding register for an accepted uncached request. The uncached bus
// sees only these registered fields, so the CPU side is free to change
// its inputs as soon as the request has been accepted.
module uc_req_buffer
  import data_path_router_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              load,
  input  logic              wr,
  input  logic [1:0]        size,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              q_wr,
  output logic [1:0]        q_size,
  output logic [ADDR_W-1:0] q_addr,
  output logic [DATA_W-1:0] q_wdata
);

  // Capture the request fields on load; cleared to zero by reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q_wr    <= 1'b0;
      q_size  <= SIZE_B;
      q_addr  <= '0;
      q_wdata <= '0;
    end else if (load) begin
      q_wr    <= wr;
      q_size  <= size;
      q_addr  <= addr;
      q_wdata <= wdata;
    end
  end

endmodule

// File: rtl/data_path_router.sv
// Data-side router: steers each translated CPU data request either to the
// D-cache (combinational pass-through) or to a single-transaction uncached
// bus port (registered and sequenced). Only one transaction is outstanding.
//
// Handshake on every port: a request transfers in a cycle where req and
// addr_ok are both 1; the target later completes it with a one-cycle
// data_ok, never in the same cycle as its addr_ok. rdata is meaningful only
// with data_ok and is forced to 0 on the CPU side otherwise.
module data_path_router
  import data_path_router_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cpu_data_req,
  input  logic              cpu_data_wr,
  input  logic [1:0]        cpu_data_size,
  input  logic [ADDR_W-1:0] cpu_data_addr,
  input  logic [DATA_W-1:0] cpu_data_wdata,
  input  logic              no_dcache,
  output logic              cpu_data_addr_ok,
  output logic              cpu_data_data_ok,
  output logic [DATA_W-1:0] cpu_data_rdata,
  output logic              cache_data_req,
  output logic              cache_data_wr,
  output logic [1:0]        cache_data_size,
  output logic [ADDR_W-1:0] cache_data_addr,
  output logic [DATA_W-1:0] cache_data_wdata,
  input  logic              cache_data_addr_ok,
  input  logic              cache_data_data_ok,
  input  logic [DATA_W-1:0] cache_data_rdata,
  output logic              uc_data_req,
  output logic              uc_data_wr,
  output logic [1:0]        uc_data_size,
  output logic [ADDR_W-1:0] uc_data_addr,
  output logic [DATA_W-1:0] uc_data_wdata,
  input  logic              uc_data_addr_ok,
  input  logic              uc_data_data_ok,
  input  logic [DATA_W-1:0] uc_data_rdata,
  output logic [1:0]        dbg_state
);

  state_t state, state_nxt;
  logic   uc_req_q;
  logic   buf_load;

  // Cache request fields are a straight pass-through; only req is gated.
  assign cache_data_wr    = cpu_data_wr;
  assign cache_data_size  = cpu_data_size;
  assign cache_data_addr  = cpu_data_addr;
  assign cache_data_wdata = cpu_data_wdata;

  assign uc_data_req = uc_req_q;
  assign dbg_state   = state;

  uc_req_buffer #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_uc_buf (
    .clk     (clk),
    .resetn  (resetn),
    .load    (buf_load),
    .wr      (cpu_data_wr),
    .size    (cpu_data_size),
    .addr    (cpu_data_addr),
    .wdata   (cpu_data_wdata),
    .q_wr    (uc_data_wr),
    .q_size  (uc_data_size),
    .q_addr  (uc_data_addr),
    .q_wdata (uc_data_wdata)
  );

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Uncached req flop: rises the cycle after CPU acceptance, drops the
  // cycle after the uncached target takes the address.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                         uc_req_q <= 1'b0;
    else if (buf_load)                   uc_req_q <= 1'b1;
    else if (uc_req_q && uc_data_addr_ok) uc_req_q <= 1'b0;
  end

  // Next-state and CPU/cache handshake muxing. Combinational outputs are
  // held at 0 while reset is asserted so nothing leaks through from IDLE.
  always_comb begin
    state_nxt        = state;
    cpu_data_addr_ok = 1'b0;
    cpu_data_data_ok = 1'b0;
    cpu_data_rdata   = '0;
    cache_data_req   = 1'b0;
    buf_load         = 1'b0;
    if (resetn) begin
      case (state)
        IDLE: begin
          if (no_dcache) begin
            cpu_data_addr_ok = cpu_data_req;
            if (cpu_data_req) begin
              buf_load  = 1'b1;
              state_nxt = UC_ADDR;
            end
          end else begin
            cache_data_req   = cpu_data_req;
            cpu_data_addr_ok = cpu_data_req & cache_data_addr_ok;
            if (cpu_data_req && cache_data_addr_ok) state_nxt = C_WAIT;
          end
        end
        C_WAIT: begin
          cpu_data_data_ok = cache_data_data_ok;
          if (cache_data_data_ok) begin
            cpu_data_rdata = cache_data_rdata;
            state_nxt      = IDLE;
          end
        end
        UC_ADDR: begin
          if (uc_data_addr_ok) state_nxt = UC_DATA;
        end
        UC_DATA: begin
          cpu_data_data_ok = uc_data_data_ok;
          if (uc_data_data_ok) begin
            cpu_data_rdata = uc_data_rdata;
            state_nxt      = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule
